// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Walks one digit slot at a time and holds every anode off for a
// guard interval at the start of each slot so the shared cathode decoder
// settles before a digit lights. Digits are captured once per frame, so a
// frame never shows a mix of old and new values. Any digit can be blinked
// for adjust mode, and the whole display can be blanked.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic        disp_en,
  output logic [3:0]  anode,
  output logic [3:0]  digit_out,
  output logic        frame_tick
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_END    = RW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  // Scan position
  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_slot;

  // Frame snapshot
  logic [15:0]   r_snapshot;
  logic          r_frame_tick;

  // Sampled control inputs
  logic [3:0]    r_mask_q;
  logic          r_disp_en_q;

  // Blink timing
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  // Registered anode drive
  logic [3:0]    r_anode;

  // Next-state helpers
  logic          w_slot_end;
  logic          w_frame_end;
  logic [RW-1:0] w_refresh_next;
  logic [1:0]    w_slot_next;
  logic          w_guard_next;
  logic          w_blink_off;
  logic          w_blank_next;
  logic [3:0]    w_anode_next;
  logic [3:0]    w_digit;

  // The last cycle of a slot advances the slot; the last cycle of slot 3 ends the frame.
  assign w_slot_end     = (r_refresh_cnt == REFRESH_LAST);
  assign w_frame_end    = w_slot_end && (r_slot == 2'd3);
  assign w_refresh_next = w_slot_end ? '0 : r_refresh_cnt + RW'(1);
  assign w_slot_next    = w_slot_end ? r_slot + 2'd1 : r_slot;

  // The anode register is loaded with the drive for the slot position it
  // will be displayed in, so the guard window lines up exactly with the
  // first GUARD cycles after a slot change.
  assign w_guard_next   = (w_refresh_next < GUARD_END);
  assign w_blink_off    = r_mask_q[w_slot_next] && r_blink_phase;
  assign w_blank_next   = w_guard_next || !r_disp_en_q || w_blink_off;
  assign w_anode_next   = w_blank_next ? 4'b1111 : ~(4'b0001 << w_slot_next);

  // Refresh counter and slot index advance continuously, even while blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_slot        <= 2'd0;
    end else begin
      r_refresh_cnt <= w_refresh_next;
      r_slot        <= w_slot_next;
    end
  end

  // Capture all four digits on the slot 3 -> 0 wrap and flag the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snapshot   <= 16'h0000;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_snapshot <= digits;
      end
      r_frame_tick <= w_frame_end;
    end
  end

  // Register the blink mask and display enable once before they touch the anodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_q    <= 4'b0000;
      r_disp_en_q <= 1'b0;
    end else begin
      r_mask_q    <= blink_mask;
      r_disp_en_q <= disp_en;
    end
  end

  // Blink half-period timer; held cleared while nothing blinks so each
  // blink episode begins with a full visible half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_mask_q == 4'b0000) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
    end
  end

  // Anode drive register: all off in reset so the display goes dark at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode <= 4'b1111;
    end else begin
      r_anode <= w_anode_next;
    end
  end

  // Select the current slot's nibble from the frame snapshot; it changes on
  // the same edge as the slot and is never replaced by a blank code.
  always_comb begin
    w_digit = r_snapshot[3:0];
    case (r_slot)
      2'd0: w_digit = r_snapshot[3:0];
      2'd1: w_digit = r_snapshot[7:4];
      2'd2: w_digit = r_snapshot[11:8];
      2'd3: w_digit = r_snapshot[15:12];
      default: w_digit = r_snapshot[3:0];
    endcase
  end

  assign anode      = r_anode;
  assign digit_out  = w_digit;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the stopwatch's 4-digit common-anode 7-segment display. It snapshots four BCD digits once per frame, walks one digit slot at a time, and presents that slot's digit to the shared digit-to-cathode decoder. It drives the active-low anodes with an inter-digit guard interval to suppress ghosting, and per-digit blink blanking for adjust mode.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal ≥ 2
- GUARD, 2000: cycles at the start of each slot with all anodes off; legal 1..REFRESH_DIV-1
- BLINK_DIV, 25000000: cycles per blink half-period; legal ≥ 1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- digits  in  16  BCD digits; digit s = digits[4s+3:4s], s=0 rightmost
- blink_mask  in  4  bit s=1: digit s blinks
- disp_en  in  1  0 forces all anodes off; counters keep running
- anode  out  4  active-low digit enables; anode[s] drives digit s
- digit_out  out  4  BCD value of the current slot, to the cathode decoder
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

## Operation
- State: refresh_cnt (0..REFRESH_DIV-1), slot (2 bits), snapshot (16 bits), blink_cnt (0..BLINK_DIV-1), blink_phase, mask_q (registered blink_mask).
- refresh_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and slot advances 0→1→2→3→0 (mod-4 wrap).
- On the edge where slot wraps 3→0: snapshot ← digits and frame_tick = 1 for that cycle (slot 0, refresh_cnt 0). Digits changing mid-frame never appear until the next frame.
- digit_out = snapshot[slot], constant for the whole slot.
- anode in state (s, p), where p = refresh_cnt:
  - 4'b1111 if p < GUARD, disp_en_q = 0, or (mask_q[s] = 1 and blink_phase = 1).
  - Otherwise only anode[s] = 0.
- Blanking is by anode only. digit_out is never forced to a blank code.
- Blink: blink_mask and disp_en are registered each cycle (mask_q, disp_en_q), so they take effect one cycle after sampling.
  - While mask_q = 0: blink_cnt = 0 and blink_phase = 0.
  - Otherwise blink_cnt counts. At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - Each blink episode therefore starts visible for a full half-period.
- anode and frame_tick are flop outputs. No combinational path from any input to any output.

## Timing
- Reset values (asserted asynchronously, immediately on rst):
  - refresh_cnt=0, slot=0, snapshot=0, blink_cnt=0, blink_phase=0, mask_q=0, disp_en_q=0
  - anode=4'b1111, digit_out=4'h0, frame_tick=0
- First frame after reset displays snapshot 0000. The first capture occurs at the first 3→0 wrap, 4·REFRESH_DIV cycles after reset release.
- Slot period is REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-GUARD cycles. Frame period is 4·REFRESH_DIV cycles.
- digit_out changes on the same edge that slot changes. Anodes are off for GUARD cycles after that edge, so the decoder has settled before any digit lights.
- blink_mask or disp_en change at edge n affects anode from edge n+2 (sample, then anode register).
- Blink period is 2·BLINK_DIV cycles; 50% duty.
- Simultaneous slot wrap and blink toggle: both take effect; anode uses the new slot and new phase.
- Reset mid-slot: anodes off immediately; scan restarts at slot 0, p=0.
- Slot and blink counters are independent; no phase alignment between them.

## Test plan
Use REFRESH_DIV=8, GUARD=2, BLINK_DIV=20 throughout.
- Reset release, digits=16'h4321, disp_en=1, mask=0:
  - anode=1111 for cycles 0–1, then 1110 for cycles 2–7, then 1111/1101 for slot 1, and so on.
  - digit_out=0 through the first frame.
  - At cycle 32: frame_tick=1 and digit_out=1. Following slots give 2, 3, 4.
- Change digits to 16'h9876 at cycle 40 (mid-frame): digit_out keeps 1,2,3,4 pattern values until cycle 64, then shows 6,7,8,9.
- mask=4'b0100 set at cycle 100:
  - From cycle 102, digit 2 is lit for 20 cycles, then dark (anode[2]=1) for 20 cycles, alternating.
  - Other digits are unaffected.
  - Clearing mask returns digit 2 to normal two cycles later.
- disp_en=0 for cycles 50–70: anode=1111 for cycles 52–71. slot, digit_out and frame_tick continue on schedule.
- Assert rst at cycle 45 (slot 1, p=5) for 3 cycles:
  - anode=1111 in the same cycle, with outputs at reset values.
  - After release, the exact first-frame sequence from scenario 1 repeats.
- Frame counter check over 1000 cycles: frame_tick occurs exactly every 32 cycles, and anode never has more than one zero bit.
